pht_ctrl: RTL and testbench
===========================

# pht_ctrl

Sequencing controller for the 16-entry pattern history table of 2-bit saturating counters in the branch predictor. It accepts branch-resolution updates over a valid/ready handshake and computes each counter's saturating next state. It drives the table's shared 2-bit write bus and one-hot write enables. It also runs a table-initialisation sweep and serves a combinational prediction lookup.

## Interface
- ENTRIES, 16, number of table entries; the one-hot enable width.
- INDEX_W, 4, index width; equals log2(ENTRIES).
- INIT_STATE, 2'b01, value written by the init sweep (weakly not-taken).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- upd_valid  in  1  update request valid.
- upd_ready  out  1  controller can accept an update.
- upd_idx  in  INDEX_W  entry to update.
- upd_taken  in  1  resolved direction; 1 = taken.
- upd_done  out  1  one-cycle pulse in the cycle the write is driven.
- init_req  in  1  start the init sweep; level, sampled in IDLE.
- busy  out  1  high in WRITE or INIT.
- cnt_in  in  2*ENTRIES  current counter values; entry i is at [2i+1:2i].
- reg_inp  out  2  shared write data to the table.
- en  out  ENTRIES  one-hot write enable to the table.
- pred_idx  in  INDEX_W  lookup index.
- pred_state  out  2  counter value for pred_idx.
- pred_taken  out  1  pred_state[1].

## Operation
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Next-state rule:
  - Taken: 11 stays 11; otherwise the counter increments by 1.
  - Not-taken: 00 stays 00; otherwise the counter decrements by 1.
  - The counter never wraps.
- FSM states are IDLE, WRITE and INIT.
- IDLE:
  - upd_ready = !init_req.
  - If init_req is high: go to INIT with sweep pointer 0. init_req has priority over upd_valid.
  - Else, if upd_valid is high: accept the update. Compute the next state from cnt_in[upd_idx] at acceptance, register it into reg_inp, set en = 1 << upd_idx, and go to WRITE.
- WRITE:
  - Lasts exactly one cycle; upd_done = 1 and upd_ready = 0.
  - Next cycle: en = 0 and return to IDLE.
- INIT:
  - Each cycle: reg_inp = INIT_STATE and en = 1 << ptr; ptr increments.
  - After ptr = ENTRIES-1 has been driven: en = 0 and return to IDLE.
  - upd_ready = 0 throughout.
  - init_req is ignored during INIT. If it is still high on return to IDLE, a new sweep starts.
- Prediction is combinational: pred_state = cnt_in[2*pred_idx +: 2], independent of FSM state. The PHT_BYPASS_EN macro modifies this (see Configuration).
- en is always one-hot or zero, never multi-hot.

## Timing
- Reset values: state IDLE, ptr 0, reg_inp 2'b00, en 0, upd_done 0, busy 0. upd_ready is 1 when init_req is low.
- Reset has priority in any state, including mid-WRITE and mid-sweep:
  - Outputs take their reset values at that edge.
  - A pending write or the remainder of the sweep is dropped.
- Update latency:
  - Accept at edge T.
  - en and reg_inp are valid for the cycle T..T+1.
  - The table captures at edge T+1.
  - IDLE again from T+1.
- Throughput: one update per 2 cycles.
- Back-to-back updates to the same index are correct without forwarding: the second update is accepted at T+2 or later, when cnt_in already reflects the first write.
- The upstream holds upd_valid, upd_idx and upd_taken stable until upd_valid && upd_ready.
- The init sweep takes ENTRIES cycles with en high. busy is high for ENTRIES cycles, then low.

## Configuration
- PHT_BYPASS_EN defined:
  - In WRITE or INIT, if pred_idx equals the entry currently being written, pred_state = reg_inp instead of cnt_in.
  - The prediction therefore reflects the value the table will hold after the next edge.
- PHT_BYPASS_EN undefined: pred_state always comes from cnt_in, i.e. one cycle stale during a write.

## Test plan
- Reset, then read all entries with cnt_in all zero -> en = 0, upd_ready = 1, pred_state = 00 for every index.
- Saturation: entry 5 = 11, upd_taken = 1 -> en = 16'h0020, reg_inp = 11. Entry 5 = 00, upd_taken = 0 -> reg_inp = 00.
- Transitions: entry 3 = 01, taken -> reg_inp = 10. Entry 3 = 10, not-taken -> reg_inp = 01. upd_done pulses once per update; upd_ready is low in the cycle after acceptance.
- init_req and upd_valid high together in IDLE -> sweep first:
  - en = 0x0001, 0x0002, … 0x8000 over 16 cycles with reg_inp = 01.
  - The update is accepted only after the sweep.
- Reset asserted on the 8th sweep cycle -> en = 0 and state IDLE at the next edge; entries 8–15 are never enabled.
- With PHT_BYPASS_EN: entry 9 = 01, taken update, pred_idx = 9 -> pred_state = 10 during WRITE.
- Without PHT_BYPASS_EN: same stimulus -> pred_state = 01 during WRITE.

Source files
------------

// File: rtl/pht_ctrl.sv
// pht_ctrl: sequencing controller for a pattern history table of 2-bit
// saturating counters. Accepts branch-resolution updates over valid/ready,
// drives the shared write bus and one-hot enables, runs an init sweep and
// serves a combinational prediction lookup.
// Optional feature macro: PHT_BYPASS_EN (prediction bypass of the in-flight write).
module pht_ctrl #(
  parameter int         ENTRIES    = 16,
  parameter int         INDEX_W    = 4,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [INDEX_W-1:0]   upd_idx,
  input  logic                 upd_taken,
  output logic                 upd_done,
  input  logic                 init_req,
  output logic                 busy,
  input  logic [2*ENTRIES-1:0] cnt_in,
  output logic [1:0]           reg_inp,
  output logic [ENTRIES-1:0]   en,
  input  logic [INDEX_W-1:0]   pred_idx,
  output logic [1:0]           pred_state,
  output logic                 pred_taken
);

  typedef enum logic [1:0] {IDLE, WRITE, INIT} state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);
  localparam logic [ENTRIES-1:0] ONE_HOT0 = {{(ENTRIES-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  // Entry being written: the update index in WRITE, the sweep pointer in INIT.
  logic [INDEX_W-1:0] ptr_reg, ptr_next;
  logic [1:0]         reg_inp_reg, reg_inp_next;

  // Unpacked view of the flat counter bus, one 2-bit counter per entry.
  logic [1:0] cnt_arr [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_unpack
      assign cnt_arr[gi] = cnt_in[2*gi +: 2];
    end
  endgenerate

  // Saturating counter step: never wraps past 00 or 11.
  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] res;
    res = cur;
    if (taken) begin
      if (cur != 2'b11) res = cur + 2'b01;
    end else begin
      if (cur != 2'b00) res = cur - 2'b01;
    end
    return res;
  endfunction

  // State, pointer and write-data registers; reset drops any pending write or sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      reg_inp_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      reg_inp_reg <= reg_inp_next;
    end
  end

  // Next-state logic and outputs; enables are decoded from the pointer so they are one-hot or zero.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    reg_inp_next = reg_inp_reg;
    upd_ready    = 1'b0;
    upd_done     = 1'b0;
    busy         = 1'b0;
    en           = '0;
    case (state_reg)
      IDLE: begin
        upd_ready = !init_req;
        if (init_req) begin
          // Sweep wins over a simultaneous update; the update waits.
          state_next   = INIT;
          ptr_next     = '0;
          reg_inp_next = INIT_STATE;
        end else if (upd_valid) begin
          state_next   = WRITE;
          ptr_next     = upd_idx;
          reg_inp_next = sat_next(cnt_arr[upd_idx], upd_taken);
        end
      end
      WRITE: begin
        upd_done   = 1'b1;
        busy       = 1'b1;
        en         = ONE_HOT0 << ptr_reg;
        state_next = IDLE;
      end
      INIT: begin
        busy = 1'b1;
        en   = ONE_HOT0 << ptr_reg;
        if (ptr_reg == LAST_IDX) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  assign reg_inp = reg_inp_reg;

  // Prediction lookup; optionally shows the value the table will hold after the next edge.
`ifdef PHT_BYPASS_EN
  assign pred_state = (busy && (pred_idx == ptr_reg)) ? reg_inp_reg : cnt_arr[pred_idx];
`else
  assign pred_state = cnt_arr[pred_idx];
`endif

  assign pred_taken = pred_state[1];

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed self-checking bench for pht_ctrl.
module tb_pht_ctrl;

  localparam int ENTRIES = 16;
  localparam int INDEX_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 upd_valid;
  logic                 upd_ready;
  logic [INDEX_W-1:0]   upd_idx;
  logic                 upd_taken;
  logic                 upd_done;
  logic                 init_req;
  logic                 busy;
  logic [2*ENTRIES-1:0] cnt_in;
  logic [1:0]           reg_inp;
  logic [ENTRIES-1:0]   en;
  logic [INDEX_W-1:0]   pred_idx;
  logic [1:0]           pred_state;
  logic                 pred_taken;

  int n_checks = 0;
  int n_errors = 0;

  logic [ENTRIES-1:0] seen_en;

  pht_ctrl #(.ENTRIES(ENTRIES), .INDEX_W(INDEX_W), .INIT_STATE(2'b01)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_done(upd_done),
    .init_req(init_req), .busy(busy),
    .cnt_in(cnt_in), .reg_inp(reg_inp), .en(en),
    .pred_idx(pred_idx), .pred_state(pred_state), .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  // Accumulate every enable seen on the table write port.
  always @(negedge clk) seen_en = seen_en | en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int idx, input logic [1:0] val);
    cnt_in[2*idx +: 2] = val;
  endtask

  // One full update transaction with hand-computed expected next state.
  task automatic do_update(input int idx, input logic taken, input logic [1:0] cur,
                           input logic [1:0] exp_next);
    logic [ENTRIES-1:0] exp_en;
    exp_en = '0;
    exp_en[idx] = 1'b1;
    set_entry(idx, cur);
    upd_idx   = INDEX_W'(idx);
    upd_taken = taken;
    upd_valid = 1'b1;
    #1;
    check("upd_ready_idle", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    check("upd_en", en, exp_en);
    check("upd_reg_inp", reg_inp, exp_next);
    check("upd_done_hi", upd_done, 1);
    check("upd_ready_lo", upd_ready, 0);
    check("upd_busy_hi", busy, 1);
    set_entry(idx, exp_next);
    tick();
    check("upd_en_clr", en, 0);
    check("upd_done_lo", upd_done, 0);
    check("upd_ready_back", upd_ready, 1);
    $display("update idx=%0d taken=%0b cur=%b -> reg_inp=%b en=0x%04h", idx, taken, cur,
             exp_next, exp_en);
  endtask

  initial begin
    logic [ENTRIES-1:0] exp_en;
    reset = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    init_req = 1'b0; cnt_in = '0; pred_idx = '0; seen_en = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_en", en, 0);
    check("rst_reg_inp", reg_inp, 0);
    check("rst_upd_ready", upd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_upd_done", upd_done, 0);
    tick();
    check("idle_en", en, 0);
    for (int i = 0; i < ENTRIES; i++) begin
      pred_idx = INDEX_W'(i);
      #1;
      check("pred_zero", pred_state, 0);
    end
    $display("reset and zero lookup done");

    // Lookup with entry i holding i mod 4.
    for (int i = 0; i < ENTRIES; i++) set_entry(i, 2'(i % 4));
    for (int i = 0; i < ENTRIES; i++) begin
      pred_idx = INDEX_W'(i);
      #1;
      check("pred_pat", pred_state, i % 4);
      check("pred_taken", pred_taken, (i % 4) >= 2);
    end
    $display("pattern lookup done");

    do_update(5, 1'b1, 2'b11, 2'b11);
    do_update(5, 1'b0, 2'b00, 2'b00);
    do_update(3, 1'b1, 2'b01, 2'b10);
    do_update(3, 1'b0, 2'b10, 2'b01);
    do_update(0, 1'b1, 2'b10, 2'b11);
    do_update(15, 1'b0, 2'b01, 2'b00);
    do_update(7, 1'b1, 2'b00, 2'b01);
    do_update(12, 1'b0, 2'b11, 2'b10);

    // Prediction during WRITE, with and without bypass.
    set_entry(9, 2'b01);
    pred_idx = 4'd9; upd_idx = 4'd9; upd_taken = 1'b1; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    check("wr_pred_reg_inp", reg_inp, 2'b10);
`ifdef PHT_BYPASS_EN
    check("wr_pred_bypass", pred_state, 2'b10);
`else
    check("wr_pred_stale", pred_state, 2'b01);
`endif
    set_entry(9, 2'b10);
    tick();
    check("wr_pred_after", pred_state, 2'b10);
    $display("write-time prediction done pred_state=%b", pred_state);

    // init_req and upd_valid together: sweep first, then the update.
    set_entry(2, 2'b01);
    init_req = 1'b1; upd_valid = 1'b1; upd_idx = 4'd2; upd_taken = 1'b1;
    #1;
    check("sweep_ready_lo", upd_ready, 0);
    tick();
    init_req = 1'b0;
    for (int k = 0; k < ENTRIES; k++) begin
      exp_en = '0;
      exp_en[k] = 1'b1;
      check("sweep_en", en, exp_en);
      check("sweep_reg_inp", reg_inp, 2'b01);
      check("sweep_busy", busy, 1);
      check("sweep_ready", upd_ready, 0);
      check("sweep_done_lo", upd_done, 0);
      set_entry(k, 2'b01);
      tick();
    end
    check("sweep_end_en", en, 0);
    check("sweep_end_busy", busy, 0);
    check("sweep_end_ready", upd_ready, 1);
    tick();
    upd_valid = 1'b0;
    check("post_sweep_en", en, 16'h0004);
    check("post_sweep_reg", reg_inp, 2'b10);
    check("post_sweep_done", upd_done, 1);
    tick();
    check("post_sweep_clr", en, 0);
    $display("sweep with pending update done");

    // Reset on the 8th sweep cycle.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    seen_en = '0;
    for (int k = 0; k < 7; k++) tick();
    check("abort_en8", en, 16'h0080);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_en", en, 0);
    check("abort_busy", busy, 0);
    check("abort_reg_inp", reg_inp, 0);
    check("abort_ready", upd_ready, 1);
    for (int k = 0; k < 20; k++) tick();
    check("abort_seen", seen_en, 16'h00FF);
    $display("sweep abort done seen_en=0x%04h", seen_en);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
